// File: rtl/sprite_blitter.sv
// Sprite blitter: walks a sprite RAM in raster order and plots clipped pixels at a screen origin.
// Optional colour-key transparency when BLIT_TRANSPARENCY_EN is defined.
module sprite_blitter #(
    parameter int unsigned WIDTH_X     = 8,
    parameter int unsigned WIDTH_Y     = 7,
    parameter int unsigned SPR_WX      = 5,
    parameter int unsigned SPR_WY      = 5,
    parameter int unsigned MAX_X       = 160,
    parameter int unsigned MAX_Y       = 120,
    parameter int unsigned RAM_LATENCY = 1,
    parameter logic [2:0]  KEY_COLOR   = 3'b000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH_X-1:0] origin_x,
    input  logic [WIDTH_Y-1:0] origin_y,
    input  logic [SPR_WX-1:0]  spr_w,
    input  logic [SPR_WY-1:0]  spr_h,
    input  logic [2:0]         pix_color,
    output logic [SPR_WX-1:0]  spr_x,
    output logic [SPR_WY-1:0]  spr_y,
    output logic [WIDTH_X-1:0] vga_x,
    output logic [WIDTH_Y-1:0] vga_y,
    output logic [2:0]         vga_color,
    output logic               vga_plot,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    localparam int unsigned SUM_WX = WIDTH_X + 1;
    localparam int unsigned SUM_WY = WIDTH_Y + 1;
    localparam int unsigned DW     = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;
    localparam int unsigned PW     = 1 + WIDTH_X + WIDTH_Y;
`ifdef BLIT_TRANSPARENCY_EN
    localparam bit TRANSP_EN = 1'b1;
`else
    localparam bit TRANSP_EN = 1'b0;
`endif

    state_t             state_q, state_d;
    logic [WIDTH_X-1:0] org_x_q;
    logic [WIDTH_Y-1:0] org_y_q;
    logic [SPR_WX-1:0]  w_q, x_d;
    logic [SPR_WY-1:0]  h_q, y_d;
    logic [DW-1:0]      drain_q, drain_d;
    logic               latch_c, last_x_c, last_y_c;

    assign last_x_c = (spr_x == SPR_WX'(w_q - SPR_WX'(1)));
    assign last_y_c = (spr_y == SPR_WY'(h_q - SPR_WY'(1)));

    // Next-state and address-counter logic
    always_comb begin
        state_d = state_q;
        x_d     = spr_x;
        y_d     = spr_y;
        drain_d = drain_q;
        latch_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    latch_c = 1'b1;
                    x_d     = '0;
                    y_d     = '0;
                    drain_d = '0;
                    state_d = (spr_w == '0 || spr_h == '0) ? DONE : SCAN;
                end
            end
            SCAN: begin
                if (last_x_c) begin
                    x_d = '0;
                    if (last_y_c) begin
                        state_d = (RAM_LATENCY == 0) ? DONE : DRAIN;
                    end else begin
                        y_d = spr_y + SPR_WY'(1);
                    end
                end else begin
                    x_d = spr_x + SPR_WX'(1);
                end
            end
            DRAIN: begin
                if (drain_q == DW'(RAM_LATENCY - 1)) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            spr_x   <= '0;
            spr_y   <= '0;
            drain_q <= '0;
            org_x_q <= '0;
            org_y_q <= '0;
            w_q     <= '0;
            h_q     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            spr_x   <= x_d;
            spr_y   <= y_d;
            drain_q <= drain_d;
            if (latch_c) begin
                org_x_q <= origin_x;
                org_y_q <= origin_y;
                w_q     <= spr_w;
                h_q     <= spr_h;
            end
            busy <= (state_d != IDLE);
            done <= (state_d == DONE);
        end
    end

    // Screen coordinate of the pixel being addressed; one extra bit so clipping sees no wrap
    logic [SUM_WX-1:0] sum_x_c;
    logic [SUM_WY-1:0] sum_y_c;
    logic              valid_c, ok_c;
    logic [PW-1:0]     stage_c, tap_c;

    assign valid_c = (state_q == SCAN);
    assign sum_x_c = SUM_WX'(org_x_q) + SUM_WX'(spr_x);
    assign sum_y_c = SUM_WY'(org_y_q) + SUM_WY'(spr_y);
    assign ok_c    = valid_c && (sum_x_c < SUM_WX'(MAX_X)) && (sum_y_c < SUM_WY'(MAX_Y));
    assign stage_c = valid_c ? {ok_c, sum_x_c[WIDTH_X-1:0], sum_y_c[WIDTH_Y-1:0]} : '0;

    // Delay line aligns coordinates with RAM read data
    generate
        if (RAM_LATENCY == 0) begin : g_no_delay
            assign tap_c = stage_c;
        end else begin : g_delay
            logic [PW-1:0] dl_q [RAM_LATENCY];
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int unsigned i = 0; i < RAM_LATENCY; i++) begin
                        dl_q[i] <= '0;
                    end
                end else begin
                    dl_q[0] <= stage_c;
                    for (int unsigned i = 1; i < RAM_LATENCY; i++) begin
                        dl_q[i] <= dl_q[i-1];
                    end
                end
            end
            assign tap_c = dl_q[RAM_LATENCY-1];
        end
    endgenerate

    // Colour arrives from the RAM in the plot cycle, so it passes straight through
    assign vga_x     = tap_c[WIDTH_Y +: WIDTH_X];
    assign vga_y     = tap_c[WIDTH_Y-1:0];
    assign vga_color = tap_c[PW-1] ? pix_color : 3'b000;
    assign vga_plot  = tap_c[PW-1] & (~TRANSP_EN | (pix_color != KEY_COLOR));

endmodule

// File: tb/tb_sprite_blitter.sv
// Bench for sprite_blitter: two instances (RAM latency 1 and 3) checked cycle by cycle against a raster model.
module tb_sprite_blitter;

    localparam int MAXX = 160;
    localparam int MAXY = 120;
`ifdef BLIT_TRANSPARENCY_EN
    localparam int TRN_PLOTS = 8;
`else
    localparam int TRN_PLOTS = 16;
`endif

    logic       clk = 1'b0;
    logic       reset, start;
    logic [7:0] origin_x;
    logic [6:0] origin_y;
    logic [4:0] spr_w, spr_h;
    logic [2:0] pix1, pix3;
    logic [4:0] sx1, sy1, sx3, sy3;
    logic [7:0] vx1, vx3;
    logic [6:0] vy1, vy3;
    logic [2:0] vc1, vc3;
    logic       vp1, vp3, busy1, busy3, done1, done3;

    int n_checks, n_fail, pat;

    always #5 clk = ~clk;

    sprite_blitter #(.RAM_LATENCY(1)) dut (
        .clk(clk), .reset(reset), .start(start), .origin_x(origin_x), .origin_y(origin_y),
        .spr_w(spr_w), .spr_h(spr_h), .pix_color(pix1), .spr_x(sx1), .spr_y(sy1),
        .vga_x(vx1), .vga_y(vy1), .vga_color(vc1), .vga_plot(vp1), .busy(busy1), .done(done1)
    );

    sprite_blitter #(.RAM_LATENCY(3)) dut3 (
        .clk(clk), .reset(reset), .start(start), .origin_x(origin_x), .origin_y(origin_y),
        .spr_w(spr_w), .spr_h(spr_h), .pix_color(pix3), .spr_x(sx3), .spr_y(sy3),
        .vga_x(vx3), .vga_y(vy3), .vga_color(vc3), .vga_plot(vp3), .busy(busy3), .done(done3)
    );

    // Sprite contents: pattern 0 never hits the key colour, pattern 1 alternates 000/101
    function automatic logic [2:0] ram_color(input int x, input int y);
        if (pat == 1) return (((x + y) % 2) == 1) ? 3'b101 : 3'b000;
        return {1'b1, 2'((x * 3 + y) % 4)};
    endfunction

    logic [2:0] p3 [3];
    always @(posedge clk) begin
        pix1  <= ram_color(int'(sx1), int'(sy1));
        p3[0] <= ram_color(int'(sx3), int'(sy3));
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign pix3 = p3[2];

    typedef struct packed {
        logic       busy, done, plot;
        logic [7:0] vx;
        logic [6:0] vy;
        logic [2:0] vc;
        logic       chk_addr;
        logic [4:0] ax, ay;
    } exp_t;

    // Expected outputs in cycle t after the start-sampling edge (t=1 is the first cycle after it)
    function automatic exp_t model(input int t, input int lat, input int ox, input int oy,
                                   input int w, input int h);
        exp_t e;
        int n, dt, k;
        e  = '0;
        n  = w * h;
        dt = (n == 0) ? 1 : 1 + n + lat;
        e.busy = (t >= 1 && t <= dt);
        e.done = (t == dt);
        k = t - 1 - lat;
        if (n > 0 && k >= 0 && k < n) begin
            int x, y;
            x = k % w;
            y = k / w;
            if (ox + x < MAXX && oy + y < MAXY
`ifdef BLIT_TRANSPARENCY_EN
                && ram_color(x, y) != 3'b000
`endif
            ) begin
                e.plot = 1'b1;
                e.vx   = 8'(ox + x);
                e.vy   = 7'(oy + y);
                e.vc   = ram_color(x, y);
            end
        end
        if (n > 0 && t >= 1 && t <= n) begin
            e.chk_addr = 1'b1;
            e.ax = 5'((t - 1) % w);
            e.ay = 5'((t - 1) / w);
        end
        return e;
    endfunction

    task automatic check_obs(input string tag, input int t, input exp_t e,
                             input logic b, input logic d, input logic p,
                             input logic [7:0] vx, input logic [6:0] vy, input logic [2:0] vc,
                             input logic [4:0] ax, input logic [4:0] ay);
        n_checks++;
        if ({b, d, p} !== {e.busy, e.done, e.plot}) begin
            n_fail++;
            $display("FAIL %s t=%0d busy/done/plot got %b%b%b want %b%b%b",
                     tag, t, b, d, p, e.busy, e.done, e.plot);
        end
        if (e.plot) begin
            n_checks++;
            if ({vx, vy, vc} !== {e.vx, e.vy, e.vc}) begin
                n_fail++;
                $display("FAIL %s t=%0d plot x/y/c got %0d/%0d/%0d want %0d/%0d/%0d",
                         tag, t, vx, vy, vc, e.vx, e.vy, e.vc);
            end
        end
        if (e.chk_addr) begin
            n_checks++;
            if ({ax, ay} !== {e.ax, e.ay}) begin
                n_fail++;
                $display("FAIL %s t=%0d addr got %0d,%0d want %0d,%0d", tag, t, ax, ay, e.ax, e.ay);
            end
        end
    endtask

    task automatic check_both(input string tag, input int t, input int ox, input int oy,
                              input int w, input int h);
        check_obs({tag, "/L1"}, t, model(t, 1, ox, oy, w, h), busy1, done1, vp1, vx1, vy1, vc1, sx1, sy1);
        check_obs({tag, "/L3"}, t, model(t, 3, ox, oy, w, h), busy3, done3, vp3, vx3, vy3, vc3, sx3, sy3);
    endtask

    task automatic check_int(input string tag, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s got %0d want %0d", tag, got, want);
        end
    endtask

    task automatic check_zero(input string tag);
        n_checks++;
        if ({sx1, sy1, vx1, vy1, vc1, vp1, busy1, done1} !== '0) begin
            n_fail++;
            $display("FAIL %s L1 outputs not zero: sx=%0d sy=%0d vx=%0d vy=%0d c=%0d p=%b b=%b d=%b",
                     tag, sx1, sy1, vx1, vy1, vc1, vp1, busy1, done1);
        end
        n_checks++;
        if ({sx3, sy3, vx3, vy3, vc3, vp3, busy3, done3} !== '0) begin
            n_fail++;
            $display("FAIL %s L3 outputs not zero: sx=%0d sy=%0d vx=%0d vy=%0d c=%0d p=%b b=%b d=%b",
                     tag, sx3, sy3, vx3, vy3, vc3, vp3, busy3, done3);
        end
    endtask

    // One blit on both instances; inputs are scrambled after acceptance, and with poke start stays high while scanning
    task automatic run_blit(input string tag, input int ox, input int oy, input int w, input int h,
                            input bit poke, output int np1, output int np3, output int dn1, output int dn3);
        int n, tend;
        n    = w * h;
        tend = ((n == 0) ? 1 : 1 + n + 3) + 2;
        np1 = 0; np3 = 0; dn1 = -1; dn3 = -1;
        check_both({tag, "/pre"}, 0, ox, oy, w, h);
        origin_x = 8'(ox); origin_y = 7'(oy); spr_w = 5'(w); spr_h = 5'(h);
        start = 1'b1;
        for (int t = 1; t <= tend; t++) begin
            @(posedge clk); #1;
            check_both(tag, t, ox, oy, w, h);
            if (vp1) np1++;
            if (vp3) np3++;
            if (done1 && dn1 < 0) dn1 = t;
            if (done3 && dn3 < 0) dn3 = t;
            if (t == 1) begin
                origin_x = 8'($urandom); origin_y = 7'($urandom);
                spr_w = 5'($urandom); spr_h = 5'($urandom);
            end
            if (!poke || t >= n) start = 1'b0;
        end
    endtask

    typedef struct {
        int ox, oy, w, h, pat, poke, exp_plots, exp_done;
    } vec_t;

    vec_t tbl[9];
    int   np1, np3, dn1, dn3;

    initial begin
        n_checks = 0; n_fail = 0; pat = 0;
        reset = 1'b1; start = 1'b0;
        origin_x = '0; origin_y = '0; spr_w = '0; spr_h = '0;

        tbl[0] = '{10, 20, 3, 2, 0, 1, 6, 8};
        tbl[1] = '{158, 118, 4, 4, 0, 1, 4, 18};
        tbl[2] = '{0, 0, 4, 4, 1, 0, TRN_PLOTS, 18};
        tbl[3] = '{0, 0, 0, 5, 0, 0, 0, 1};
        tbl[4] = '{0, 0, 5, 0, 0, 0, 0, 1};
        tbl[5] = '{5, 3, 1, 1, 0, 0, 1, 3};
        tbl[6] = '{159, 119, 2, 2, 0, 1, 1, 6};
        tbl[7] = '{255, 127, 3, 3, 0, 0, 0, 11};
        tbl[8] = '{150, 100, 31, 31, 0, 1, 200, 963};

        repeat (2) @(posedge clk);
        #1;
        check_zero("reset_state");
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("idle_after_reset");

        foreach (tbl[i]) begin
            pat = tbl[i].pat;
            run_blit($sformatf("vec%0d", i), tbl[i].ox, tbl[i].oy, tbl[i].w, tbl[i].h,
                     tbl[i].poke != 0, np1, np3, dn1, dn3);
            check_int($sformatf("vec%0d plots L1", i), np1, tbl[i].exp_plots);
            check_int($sformatf("vec%0d plots L3", i), np3, tbl[i].exp_plots);
            check_int($sformatf("vec%0d done L1", i), dn1, tbl[i].exp_done);
            check_int($sformatf("vec%0d done L3", i), dn3,
                      (tbl[i].w * tbl[i].h == 0) ? tbl[i].exp_done : tbl[i].exp_done + 2);
        end

        // start held through DONE is ignored there, then accepted in the following IDLE
        pat = 0;
        origin_x = 8'd7; origin_y = 7'd9; spr_w = 5'd0; spr_h = 5'd3; start = 1'b1;
        @(posedge clk); #1; check_both("restart_c1", 1, 7, 9, 0, 3);
        @(posedge clk); #1; check_both("restart_c2", 2, 7, 9, 0, 3);
        @(posedge clk); #1; check_both("restart_c3", 1, 7, 9, 0, 3);
        start = 1'b0;
        @(posedge clk); #1; check_both("restart_c4", 2, 7, 9, 0, 3);
        @(posedge clk); #1;

        // Reset in the middle of a 5x5 scan
        origin_x = 8'd20; origin_y = 7'd30; spr_w = 5'd5; spr_h = 5'd5; start = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            @(posedge clk); #1;
            start = 1'b0;
            check_both("pre_abort", t, 20, 30, 5, 5);
        end
        #2 reset = 1'b1;
        #1 check_zero("reset_mid_scan");
        @(posedge clk); #1;
        check_zero("reset_held");
        reset = 1'b0;
        for (int t = 1; t <= 8; t++) begin
            @(posedge clk); #1;
            check_both("post_abort", 0, 20, 30, 5, 5);
        end
        run_blit("after_abort", 20, 30, 5, 5, 1'b0, np1, np3, dn1, dn3);
        check_int("after_abort plots L1", np1, 25);
        check_int("after_abort done L1", dn1, 27);
        check_int("after_abort done L3", dn3, 29);

        // Randomised blits
        for (int r = 0; r < 12; r++) begin
            int ox, oy, w, h;
            ox  = int'($urandom_range(0, 255));
            oy  = int'($urandom_range(0, 127));
            w   = int'($urandom_range(0, 6));
            h   = int'($urandom_range(0, 6));
            pat = int'($urandom_range(0, 1));
            run_blit($sformatf("rand%0d", r), ox, oy, w, h, $urandom_range(0, 1) == 1,
                     np1, np3, dn1, dn3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sprite_blitter.md
SPRITE_BLITTER -- requirements
Module: sprite_blitter

Interface
REQ-001 SHALL have parameter WIDTH_X, default 8, screen x-coordinate width.
REQ-002 SHALL have parameter WIDTH_Y, default 7, screen y-coordinate width.
REQ-003 SHALL have parameter SPR_WX, default 5, sprite-local x width.
REQ-004 SHALL have parameter SPR_WY, default 5, sprite-local y width.
REQ-005 SHALL have parameter MAX_X, default 160, screen width in pixels (clip bound).
REQ-006 SHALL have parameter MAX_Y, default 120, screen height in pixels (clip bound).
REQ-007 SHALL have parameter RAM_LATENCY, default 1, range 0..4: sprite RAM read latency in cycles.
REQ-008 SHALL have parameter KEY_COLOR, default 3'b000, transparent colour.
REQ-009 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-010 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-011 SHALL have port start, input, 1, request to blit one sprite.
REQ-012 SHALL have port origin_x, input, WIDTH_X, screen x of sprite top-left.
REQ-013 SHALL have port origin_y, input, WIDTH_Y, screen y of sprite top-left.
REQ-014 SHALL have port spr_w, input, SPR_WX, sprite width in pixels.
REQ-015 SHALL have port spr_h, input, SPR_WY, sprite height in pixels.
REQ-016 SHALL have port pix_color, input, 3, sprite RAM read data.
REQ-017 SHALL have ports spr_x / spr_y, outputs, SPR_WX / SPR_WY, sprite RAM address.
REQ-018 SHALL have ports vga_x / vga_y, outputs, WIDTH_X / WIDTH_Y, plot coordinate.
REQ-019 SHALL have port vga_color, output, 3, plot colour.
REQ-020 SHALL have port vga_plot, output, 1, plot strobe.
REQ-021 SHALL have ports busy and done, outputs, 1 each: busy level and 1-cycle done pulse.

Function
REQ-022 SHALL implement states IDLE, SCAN, DRAIN, DONE.
REQ-023 In IDLE, start=1 SHALL latch origin_x, origin_y, spr_w and spr_h, and the block SHALL then ignore these inputs until the next IDLE.
REQ-024 start SHALL be ignored outside IDLE.
REQ-025 Start sampled at edge N with nonzero dimensions SHALL enter SCAN at N+1 with spr_x=0 and spr_y=0.
REQ-026 SCAN SHALL issue one address per cycle in raster order: spr_x increments; at spr_w-1 it wraps to 0 and spr_y increments.
REQ-027 After address (spr_w-1, spr_h-1), the state SHALL go to DRAIN for RAM_LATENCY cycles (skipped if 0), then to DONE for exactly 1 cycle, then to IDLE.
REQ-028 Pixel k SHALL be addressed at cycle N+1+k and, if enabled, plotted at cycle N+1+k+RAM_LATENCY, using a valid/coordinate delay line of depth RAM_LATENCY.
REQ-029 vga_x SHALL equal origin_x+spr_x and vga_y SHALL equal origin_y+spr_y, both delayed with pixel k; sums SHALL be computed one bit wider than the operand so they never wrap.
REQ-030 vga_plot SHALL be asserted only if the pixel is valid, the unwrapped vga_x < MAX_X and the unwrapped vga_y < MAX_Y; clipped pixels SHALL still consume their cycle.
REQ-031 vga_color SHALL equal pix_color in the plot cycle.
REQ-032 busy SHALL be 1 from the cycle after start is accepted through the DONE cycle inclusive, and 0 otherwise.
REQ-033 done SHALL be 1 only in the DONE cycle, at N+1+spr_w*spr_h+RAM_LATENCY.
REQ-034 If spr_w=0 or spr_h=0, the block SHALL go IDLE->DONE at N+1 with no vga_plot.
REQ-035 start asserted in the DONE cycle SHALL be ignored; start in the following IDLE cycle SHALL be accepted.

Reset
REQ-036 reset SHALL asynchronously force IDLE and clear spr_x, spr_y, vga_x, vga_y, vga_color, vga_plot, busy, done and the delay line to 0, including during SCAN or DRAIN.
REQ-037 After reset is released, no plot from an aborted blit SHALL appear.

Configuration
REQ-038 With BLIT_TRANSPARENCY_EN defined, vga_plot SHALL additionally require pix_color != KEY_COLOR.
REQ-039 Without BLIT_TRANSPARENCY_EN, every unclipped valid pixel SHALL plot, and KEY_COLOR SHALL be unused.

Verification
REQ-040 Check: RAM_LATENCY=1, origin (10,20), size 3x2, start at edge 0 -> plots at cycles 2..7 at (10,20),(11,20),(12,20),(10,21),(11,21),(12,21); done at cycle 8.
REQ-041 Check: origin (158,118), size 4x4 -> only (158,118),(159,118),(158,119),(159,119) plot; done at 1+16+L.
REQ-042 Check: BLIT_TRANSPARENCY_EN, pix_color alternating 000/101 -> plots only on 101 pixels; without the macro -> all 16 pixels of a 4x4 sprite plot.
REQ-043 Check: spr_w=0, spr_h=5 -> done at cycle 1, busy high for 1 cycle, zero plots.
REQ-044 Check: reset pulse during SCAN of a 5x5 sprite -> all outputs 0 immediately, no later plots, and a new start is accepted normally.
REQ-045 Check: RAM_LATENCY=3 with start re-asserted while busy -> re-assertion ignored; plots offset 3 cycles from addresses; done at 1+W*H+3.
